mem_copy_engine: RTL and testbench

Initiator-side engine that drives the port of the 64 × 32-bit single-port synchronous memory (registered read data, one-cycle read latency, read data forced to zero when not reading). Given a one-cycle start command, it either copies a block of words from a source to a destination address range, or fills a range with a constant pattern. It reports `busy` and `done`. It sits between the control logic and the scratch memory, and is the sole master of that memory's port while busy.

---
 rtl/mem_copy_engine_pkg.sv | 20 ++
 rtl/mem_copy_engine.sv | 112 +++++++++++
 tb/tb_mem_copy_engine.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy/fill engine: default widths,
// command mode encoding and the controller state encoding.
package mem_copy_engine_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 6;
    localparam int LEN_W      = DEF_ADDR_W + 1;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_FILL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Copy/fill engine mastering a single-port synchronous scratch memory.
// Copies alternate one read and one write per word; fills write one word per cycle.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int LW = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic              mode_q;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LW-1:0]     len_q;
    logic [DATA_W-1:0] fill_q;
    logic              cmd_load;

    logic [LW-1:0]     idx_nxt;
    logic              last;
    logic [ADDR_W-1:0] src_cur, dst_cur;

    // Index is one bit wider than an address so len=64 terminates; the
    // address sums drop that bit and wrap around the memory.
    assign idx_nxt = idx_q + LW'(1);
    assign last    = (idx_nxt == len_q);
    assign src_cur = src_q + idx_q[ADDR_W-1:0];
    assign dst_cur = dst_q + idx_q[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mode_q  <= MODE_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (cmd_load) begin
                mode_q <= mode;
                src_q  <= src_addr;
                dst_q  <= dst_addr;
                len_q  <= len;
                fill_q <= fill_data;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cmd_load = 1'b0;
        busy     = (state_q != ST_IDLE);
        done     = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        mem_wen  = 1'b0;
        mem_ren  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cmd_load = 1'b1;
                    idx_d    = '0;
                    if (len == '0)              state_d = ST_DONE;
                    else if (mode == MODE_COPY) state_d = ST_RD;
                    else                        state_d = ST_FILL;
                end
            end
            ST_RD: begin
                mem_ren  = 1'b1;
                mem_addr = src_cur;
                state_d  = ST_WR;
            end
            ST_WR, ST_FILL: begin
                // Copy writes forward the word read in the previous cycle.
                mem_wen  = 1'b1;
                mem_addr = dst_cur;
                mem_din  = (mode_q == MODE_FILL) ? fill_q : mem_dout;
                idx_d    = idx_nxt;
                if (last)                   state_d = ST_DONE;
                else if (mode_q == MODE_FILL) state_d = ST_FILL;
                else                        state_d = ST_RD;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine against a 64x32 registered-read memory model;
// expected writes are queued per command and popped as the engine writes.
module tb_mem_copy_engine;

    localparam int DW = 32;
    localparam int AW = 6;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset, start, mode;
    logic [AW-1:0] src_addr, dst_addr;
    logic [AW:0]   len;
    logic [DW-1:0] fill_data;
    logic          busy, done, mem_wen, mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    logic          tb_own, tb_wen, tb_ren;
    logic [AW-1:0] tb_addr;
    logic [DW-1:0] tb_din;
    logic          m_wen, m_ren;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din, rdata;
    logic [DW-1:0] ram    [64];
    logic [DW-1:0] shadow [64];

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_dout(mem_dout)
    );

    // The bench borrows the memory port only while the engine is idle.
    assign m_wen  = tb_own ? tb_wen  : mem_wen;
    assign m_ren  = tb_own ? tb_ren  : mem_ren;
    assign m_addr = tb_own ? tb_addr : mem_addr;
    assign m_din  = tb_own ? tb_din  : mem_din;
    assign mem_dout = rdata;

    always_ff @(posedge clk) begin
        if (m_wen) ram[m_addr] <= m_din;
        rdata <= m_ren ? ram[m_addr] : '0;
    end

    task automatic tb_write(input int a, input logic [DW-1:0] d);
        tb_own = 1'b1; tb_wen = 1'b1; tb_addr = AW'(a); tb_din = d;
        @(posedge clk); #1;
        tb_own = 1'b0; tb_wen = 1'b0;
        shadow[a] = d;
    endtask

    task automatic check_range(input string name, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            int a;
            a = (base + k) % 64;
            tb_own = 1'b1; tb_ren = 1'b1; tb_addr = AW'(a);
            @(posedge clk); #1;
            tb_own = 1'b0; tb_ren = 1'b0;
            checks++;
            if (rdata !== shadow[a]) begin
                errors++;
                $display("FAIL %s readback mem[%0d]: got %08h want %08h", name, a, rdata, shadow[a]);
            end
        end
    endtask

    // Issues one command and watches the port; with poke set, a conflicting
    // start with different parameters is pulsed in cycle 2 while busy.
    task automatic run_cmd(input string name, input logic md, input int src, input int dst,
                           input int n, input logic [DW-1:0] fd, input bit poke);
        int  exp_done, nbusy, nren, ndone, dcyc, nboth;
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = AW'((dst + i) % 64);
            w.data = md ? fd : shadow[(src + i) % 64];
            w.cyc  = md ? i + 1 : 2 * (i + 1);
            shadow[w.addr] = w.data;
            exp_q.push_back(w);
        end
        exp_done = (n == 0) ? 1 : (md ? n + 1 : 2 * n + 1);
        nbusy = 0; nren = 0; ndone = 0; dcyc = -1; nboth = 0;
        mode = md; src_addr = AW'(src); dst_addr = AW'(dst);
        len = (AW+1)'(n); fill_data = fd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
            if (poke && cyc == 2) begin
                start = 1'b1; mode = ~md; src_addr = 6'd50; dst_addr = 6'd20;
                len = 7'd5; fill_data = 32'hDEAD_BEEF;
            end
            if (poke && cyc == 3) start = 1'b0;
            @(negedge clk);
            if (mem_ren && mem_wen) nboth++;
            if (mem_ren) nren++;
            if (busy) nbusy++;
            if (done) begin ndone++; dcyc = cyc; end
            if (mem_wen) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra write: cycle %0d addr %0d data %08h, none required",
                             name, cyc, mem_addr, mem_din);
                end else begin
                    w = exp_q.pop_front();
                    if (mem_addr !== w.addr || mem_din !== w.data || cyc != w.cyc) begin
                        errors++;
                        $display("FAIL %s write: got cycle %0d addr %0d data %08h want cycle %0d addr %0d data %08h",
                                 name, cyc, mem_addr, mem_din, w.cyc, w.addr, w.data);
                    end
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ndone != 1 || dcyc != exp_done) begin
            errors++;
            $display("FAIL %s done: got %0d pulses last at cycle %0d want 1 at cycle %0d", name, ndone, dcyc, exp_done);
        end
        checks++;
        if (nbusy != exp_done) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d want %0d", name, nbusy, exp_done);
        end
        checks++;
        if (nren != (md ? 0 : n) || nboth != 0) begin
            errors++;
            $display("FAIL %s reads: got %0d reads %0d overlaps want %0d reads 0 overlaps",
                     name, nren, nboth, md ? 0 : n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing writes: got %0d outstanding want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, mem_wen, mem_ren} !== 4'b0 || mem_addr !== '0 || mem_din !== '0) begin
            errors++;
            $display("FAIL reset outputs: got busy=%b done=%b wen=%b ren=%b addr=%0d din=%08h want all 0",
                     busy, done, mem_wen, mem_ren, mem_addr, mem_din);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 64; k++) tb_write(k, 32'hC0DE_0000 ^ (k * 32'h0101_0101));
    endtask

    task automatic test_fill();
        run_cmd("fill", 1'b1, 0, 10, 4, 32'hA5A5_0001, 1'b0);
        check_range("fill", 9, 6);
    endtask

    task automatic test_copy();
        for (int k = 0; k < 8; k++) tb_write(k, 32'h100 + k);
        run_cmd("copy", 1'b0, 0, 32, 8, 32'h0, 1'b0);
        check_range("copy", 32, 8);
    endtask

    // Source word 1 is overwritten before it is read, so dst word 4 gets
    // the freshly copied value 1 rather than the original 4.
    task automatic test_wrap();
        tb_write(62, 32'd1); tb_write(63, 32'd2); tb_write(0, 32'd3); tb_write(1, 32'd4);
        run_cmd("wrap", 1'b0, 62, 1, 4, 32'h0, 1'b0);
        check_range("wrap", 62, 8);
    endtask

    task automatic test_len_zero();
        run_cmd("len0_copy", 1'b0, 5, 20, 0, 32'h0, 1'b0);
        run_cmd("len0_fill", 1'b1, 5, 20, 0, 32'hFFFF_FFFF, 1'b0);
        check_range("len0", 20, 2);
    endtask

    task automatic test_start_while_busy();
        run_cmd("busy_start", 1'b0, 2, 48, 3, 32'h0, 1'b1);
        check_range("busy_start", 48, 3);
        check_range("busy_start_dst2", 20, 5);
    endtask

    task automatic test_full_fill();
        run_cmd("fill64", 1'b1, 0, 17, 64, 32'h1234_5678, 1'b0);
        check_range("fill64", 15, 4);
    endtask

    task automatic test_reset_mid_fill();
        int ndone;
        ndone = 0;
        for (int k = 0; k < 8; k++) tb_write(40 + k, 32'h5500 + k);
        mode = 1'b1; dst_addr = 6'd40; len = 7'd8; fill_data = 32'h0000_0077; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            if (cyc == 2) reset = 1'b1;
            if (cyc == 3) reset = 1'b0;
            @(negedge clk);
            if (done) ndone++;
            if (cyc == 3) begin
                checks++;
                if ({busy, done, mem_wen, mem_ren} !== 4'b0 || mem_addr !== '0 || mem_din !== '0) begin
                    errors++;
                    $display("FAIL mid_reset outputs: got busy=%b done=%b wen=%b ren=%b addr=%0d din=%08h want all 0",
                             busy, done, mem_wen, mem_ren, mem_addr, mem_din);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL mid_reset done: got %0d pulses want 0", ndone);
        end
        shadow[40] = 32'h0000_0077;
        shadow[41] = 32'h0000_0077;
        check_range("mid_reset", 40, 8);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0;
        tb_own = 1'b0; tb_wen = 1'b0; tb_ren = 1'b0; tb_addr = '0; tb_din = '0;
        test_reset();
        test_fill();
        test_copy();
        test_wrap();
        test_len_zero();
        test_start_while_busy();
        test_full_fill();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
